// File: rtl/lrn_padded_reader.sv
// Walks a padded LRN output tensor in linear address order, synthesising zero
// borders locally and reading interior words from the GLB into a ready/valid stream.
module lrn_padded_reader #(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      start_read,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
  output logic [ADDR_BUS_WIDTH-1:0] r_addr,
  output logic                      r_enable,
  input  logic [DATA_WIDTH-1:0]     r_data,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int E1 = E_WIDTH + 1;
  localparam int F1 = F_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                    r_state;
  logic [N_WIDTH-1:0]        r_dim4;
  logic [M_WIDTH-1:0]        r_dim3;
  logic [E_WIDTH-1:0]        r_dim2, r_p2, r_c2;
  logic [F_WIDTH-1:0]        r_dim1, r_p1, r_c1;
  logic [M_WIDTH-1:0]        r_c3;
  logic [N_WIDTH-1:0]        r_c4;
  logic [V_WIDTH-1:0]        r_pad;
  logic [ADDR_BUS_WIDTH-1:0] r_lin;

  logic                      r_inflight, r_inflight_border, r_inflight_last;

  logic [DATA_WIDTH-1:0]     r_fifo_data [2];
  logic                      r_fifo_last [2];
  logic                      r_wr_ptr, r_rd_ptr;
  logic [1:0]                r_count;

  logic [E_WIDTH-1:0]        w_p2_in;
  logic [F_WIDTH-1:0]        w_p1_in;
  logic                      w_zero_cfg;
  logic                      w_border;
  logic                      w_p2_end, w_p1_end, w_i3_end, w_i4_end, w_last_elem;
  logic                      w_pop, w_push, w_can_issue;
  logic [2:0]                w_occ;
  logic [DATA_WIDTH-1:0]     w_push_data;

  assign w_p2_in    = dim2 + (E_WIDTH'(padding_num) << 1);
  assign w_p1_in    = dim1 + (F_WIDTH'(padding_num) << 1);
  assign w_zero_cfg = (dim1 == '0) || (dim2 == '0) || (dim3 == '0) || (dim4 == '0) ||
                      (w_p1_in == '0) || (w_p2_in == '0);

  // Extra bit on the upper bound keeps dim+pad from wrapping at full-scale dims.
  assign w_border = (r_c2 < E_WIDTH'(r_pad)) ||
                    ({1'b0, r_c2} >= ({1'b0, r_dim2} + E1'(r_pad))) ||
                    (r_c1 < F_WIDTH'(r_pad)) ||
                    ({1'b0, r_c1} >= ({1'b0, r_dim1} + F1'(r_pad)));

  assign w_p2_end    = (r_c2 == r_p2 - 1'b1);
  assign w_p1_end    = (r_c1 == r_p1 - 1'b1);
  assign w_i3_end    = (r_c3 == r_dim3 - 1'b1);
  assign w_i4_end    = (r_c4 == r_dim4 - 1'b1);
  assign w_last_elem = w_p2_end && w_p1_end && w_i3_end && w_i4_end;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = r_fifo_last[r_rd_ptr];
  assign w_pop     = out_valid && out_ready;

  // Occupancy credits the pop happening this cycle so a full-rate stream never stalls.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_can_issue = (r_state == ISSUE) && (w_occ < 3'd2);

  // The GLB samples the request at the edge closing this cycle, so strobe and
  // address are presented in the issuing cycle itself.
  assign r_enable = w_can_issue && !w_border;
  assign r_addr   = r_lin;

  assign w_push      = r_inflight;
  assign w_push_data = r_inflight_border ? '0 : r_data;

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge core_clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_dim4            <= '0;
      r_dim3            <= '0;
      r_dim2            <= '0;
      r_dim1            <= '0;
      r_pad             <= '0;
      r_p2              <= '0;
      r_p1              <= '0;
      r_c1              <= '0;
      r_c2              <= '0;
      r_c3              <= '0;
      r_c4              <= '0;
      r_lin             <= '0;
      r_inflight        <= 1'b0;
      r_inflight_border <= 1'b0;
      r_inflight_last   <= 1'b0;
      // NOTE: the two FIFO slots are reset because the head drives out_data
      // directly and must read zero after reset; a larger RAM would not be.
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr          <= 1'b0;
      r_rd_ptr          <= 1'b0;
      r_count           <= 2'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      r_inflight        <= w_can_issue;
      r_inflight_border <= w_border;
      r_inflight_last   <= w_last_elem;
      done              <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (start_read) begin
            r_dim4 <= dim4;
            r_dim3 <= dim3;
            r_dim2 <= dim2;
            r_dim1 <= dim1;
            r_pad  <= padding_num;
            r_p2   <= w_p2_in;
            r_p1   <= w_p1_in;
            r_c1   <= '0;
            r_c2   <= '0;
            r_c3   <= '0;
            r_c4   <= '0;
            r_lin  <= '0;
            if (w_zero_cfg) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state <= ISSUE;
              busy    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_can_issue) begin
            r_lin <= r_lin + 1'b1;
            if (w_p2_end) begin
              r_c2 <= '0;
              if (w_p1_end) begin
                r_c1 <= '0;
                if (w_i3_end) begin
                  r_c3 <= '0;
                  r_c4 <= r_c4 + 1'b1;
                end else begin
                  r_c3 <= r_c3 + 1'b1;
                end
              end else begin
                r_c1 <= r_c1 + 1'b1;
              end
            end else begin
              r_c2 <= r_c2 + 1'b1;
            end
            if (w_last_elem) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Popping the tagged last entry implies FIFO and tag are both empty after this edge.
          if (w_pop && out_last) begin
            r_state <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_lin   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
